// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
// The PARITY_CHECK_EN build uses ST_PAR. The default build never enters it.
package sipo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_e;

  // Ceiling log2. The result is never below 1, so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >>> 1;
    end
    return (res < 1) ? 1 : res;
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-word holding buffer with valid/ready output.
// A word that completes while the buffer is full and not being drained is dropped, and an overrun pulse flags it.
module sipo_out_buf
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_vld,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;
  logic             overrun_d, overrun_q;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load_vld) begin
      // A same-edge drain frees the slot, so the new word follows with no bubble.
      if (!valid_q || out_ready) begin
        data_d  = load_data;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Assembles a sync-framed serial stream into WIDTH-bit words and passes them to sipo_out_buf.
// Define PARITY_CHECK_EN to take one trailing even-parity bit per word and raise parity_err on a mismatch.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CNT_W = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] bit_cnt_d, bit_cnt_q;
  logic [WIDTH-1:0] shreg_d, shreg_q;
  logic [WIDTH-1:0] shifted, fresh;
  logic             word_vld;
  logic [WIDTH-1:0] word_data;
`ifdef PARITY_CHECK_EN
  logic             parity_err_d, parity_err_q;
`endif

  always_comb begin
    // In both modes, the first captured bit reaches its final position after WIDTH shifts.
    if (MSB_FIRST) begin
      shifted = {shreg_q[WIDTH-2:0], sin};
      fresh   = {{(WIDTH-1){1'b0}}, sin};
    end else begin
      shifted = {sin, shreg_q[WIDTH-1:1]};
      fresh   = {sin, {(WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    word_vld  = 1'b0;
    word_data = shreg_q;
`ifdef PARITY_CHECK_EN
    parity_err_d = 1'b0;
`endif
    if (sin_valid) begin
      if (sync) begin
        // sync always starts a new word and discards any partial one.
        shreg_d   = fresh;
        bit_cnt_d = CNT_W'(1);
        state_d   = ST_SHIFT;
      end else begin
        case (state_q)
          ST_SHIFT: begin
            shreg_d = shifted;
            if (bit_cnt_q == LAST_IDX) begin
`ifdef PARITY_CHECK_EN
              state_d   = ST_PAR;
              bit_cnt_d = CNT_W'(WIDTH);
`else
              state_d   = ST_IDLE;
              bit_cnt_d = '0;
              word_vld  = 1'b1;
              word_data = shifted;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
`ifdef PARITY_CHECK_EN
          ST_PAR: begin
            // Even parity: the word bits and the parity bit together hold an even number of ones.
            state_d      = ST_IDLE;
            bit_cnt_d    = '0;
            word_vld     = 1'b1;
            word_data    = shreg_q;
            parity_err_d = ^{shreg_q, sin};
          end
`endif
          default: begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  sipo_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_vld (word_vld),
    .load_data(word_data),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .overrun  (overrun)
  );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: MSB-first and LSB-first instances share one stimulus stream.
// A bit-queue reference model checks both instances, and each test also checks fixed expected words.
module tb_sipo_deserializer;

`ifdef PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
  localparam int NB     = 9;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int NB     = 8;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sin = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sync = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] d1_data, d0_data;
  logic       d1_valid, d0_valid, d1_ovr, d0_ovr, d1_perr, d0_perr;

  int checks = 0;
  int failures = 0;
  int vld1_seen = 0;
  int ovr1_seen = 0;
  int ovr0_seen = 0;

  // Reference model state
  bit         mq[$];
  logic       m_full;
  logic [7:0] m_data1, m_data0;
  logic       m_ovr, m_perr;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .out_data(d1_data), .out_valid(d1_valid), .out_ready(out_ready),
    .overrun(d1_ovr), .parity_err(d1_perr));

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .out_data(d0_data), .out_valid(d0_valid), .out_ready(out_ready),
    .overrun(d0_ovr), .parity_err(d0_perr));

  always @(negedge clk) begin
    if (d1_valid) vld1_seen++;
    if (d1_ovr) ovr1_seen++;
    if (d0_ovr) ovr0_seen++;
  end

  task automatic model_reset();
    mq.delete();
    m_full = 1'b0; m_data1 = '0; m_data0 = '0; m_ovr = 1'b0; m_perr = 1'b0;
  endtask

  // Applies the stated rules for one rising edge: bits collected since the last sync form a word.
  task automatic model_edge(input logic s, input logic v, input logic y, input logic r);
    bit         done;
    logic [7:0] w1, w0;
    done = 0; w1 = '0; w0 = '0;
    m_ovr = 1'b0; m_perr = 1'b0;
    if (v) begin
      if (y) begin
        mq.delete();
        mq.push_back(s);
      end else if (mq.size() > 0) begin
        mq.push_back(s);
      end
      if (mq.size() == NB) begin
        done = 1;
        for (int i = 0; i < 8; i++) begin
          w1[7-i] = mq[i];
          w0[i]   = mq[i];
        end
        if (PAR_EN) m_perr = (($countones(w1) + int'(mq[NB-1])) % 2) != 0;
        mq.delete();
      end
    end
    if (done) begin
      if (!m_full || r) begin
        m_full = 1'b1; m_data1 = w1; m_data0 = w0;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_full && r) begin
      m_full = 1'b0;
    end
  endtask

  task automatic step(input logic s, input logic v, input logic y, input logic r);
    sin = s; sin_valid = v; sync = y; out_ready = r;
    @(posedge clk);
    model_edge(s, v, y, r);
    #1;
  endtask

  task automatic send_word(input logic [7:0] seq, input logic r);
    for (int i = 0; i < 8; i++) step(seq[7-i], 1'b1, i == 0, r);
    if (PAR_EN) step(^seq, 1'b1, 1'b0, r);
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) o[i] = x[7-i];
    return o;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      sin = 1'(i % 2); sin_valid = 1'b1; sync = 1'($urandom % 2); out_ready = 1'($urandom % 2);
      @(posedge clk); #1;
      checks++;
      if ({d1_valid, d1_data, d1_ovr, d0_valid, d0_data, d0_ovr} !== 18'd0) begin
        failures++;
        $display("FAIL reset_hold: got v=%b d=%h o=%b / v=%b d=%h o=%b required all 0",
                 d1_valid, d1_data, d1_ovr, d0_valid, d0_data, d0_ovr);
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'($urandom % 2), 1'b1, 1'b0, 1'($urandom % 2));
      checks++;
      if ({d1_valid, d1_data, d1_ovr, d0_valid, d0_data, d0_ovr} !== 18'd0) begin
        failures++;
        $display("FAIL reset_release_nosync: got v=%b d=%h o=%b / v=%b d=%h o=%b required all 0",
                 d1_valid, d1_data, d1_ovr, d0_valid, d0_data, d0_ovr);
      end
    end
  endtask

  task automatic test_single_word();
    int v0;
    v0 = vld1_seen;
    send_word(8'hA5, 1'b1);
    checks++;
    if ({d1_valid, d1_data, d0_valid, d0_data} !== {1'b1, 8'hA5, 1'b1, 8'hA5}) begin
      failures++;
      $display("FAIL word_a5: got msb v=%b d=%h lsb v=%b d=%h required 1/a5 1/a5",
               d1_valid, d1_data, d0_valid, d0_data);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ((vld1_seen - v0) !== 1 || d1_valid !== 1'b0) begin
      failures++;
      $display("FAIL word_a5_one_cycle: got %0d valid cycles (now %b) required 1 (now 0)",
               vld1_seen - v0, d1_valid);
    end
    send_word(8'hC0, 1'b1);
    checks++;
    if ({d1_data, d0_data} !== {8'hC0, 8'h03} || d1_perr !== 1'b0) begin
      failures++;
      $display("FAIL word_c0_03: got msb=%h lsb=%h perr=%b required c0 03 0", d1_data, d0_data, d1_perr);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int o1, o0;
    o1 = ovr1_seen; o0 = ovr0_seen;
    send_word(8'h3C, 1'b0);
    send_word(8'hC3, 1'b0);
    checks++;
    if ({d1_valid, d1_data, d0_data} !== {1'b1, 8'h3C, 8'h3C}) begin
      failures++;
      $display("FAIL bp_hold: got v=%b msb=%h lsb=%h required 1 3c 3c", d1_valid, d1_data, d0_data);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ((ovr1_seen - o1) !== 1 || (ovr0_seen - o0) !== 1) begin
      failures++;
      $display("FAIL bp_overrun_count: got %0d/%0d pulses required 1/1", ovr1_seen - o1, ovr0_seen - o0);
    end
    checks++;
    if ({d1_valid, d0_valid, d1_data} !== {1'b0, 1'b0, 8'h3C}) begin
      failures++;
      $display("FAIL bp_drain: got v=%b/%b d=%h required 0/0 3c", d1_valid, d0_valid, d1_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    int o1;
    o1 = ovr1_seen;
    send_word(8'h5A, 1'b0);
    seq = 8'h96;
    for (int i = 0; i < 8; i++) step(seq[7-i], 1'b1, i == 0, (i == 7) && !PAR_EN);
    if (PAR_EN) step(^seq, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({d1_valid, d1_data, d0_valid, d0_data} !== {1'b1, 8'h96, 1'b1, rev8(8'h96)}) begin
      failures++;
      $display("FAIL b2b_load: got msb v=%b d=%h lsb v=%b d=%h required 1/96 1/%h",
               d1_valid, d1_data, d0_valid, d0_data, rev8(8'h96));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ((ovr1_seen - o1) !== 0 || d1_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: got ovr=%0d v=%b required 0 0", ovr1_seen - o1, d1_valid);
    end
  endtask

  task automatic test_resync();
    int v0, o1;
    v0 = vld1_seen; o1 = ovr1_seen;
    for (int i = 0; i < 4; i++) step(1'($urandom % 2), 1'b1, i == 0, 1'b1);
    send_word(8'h81, 1'b1);
    checks++;
    if ({d1_data, d0_data} !== {8'h81, 8'h81}) begin
      failures++;
      $display("FAIL resync_word: got msb=%h lsb=%h required 81 81", d1_data, d0_data);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ((vld1_seen - v0) !== 1 || (ovr1_seen - o1) !== 0) begin
      failures++;
      $display("FAIL resync_count: got words=%0d ovr=%0d required 1 0", vld1_seen - v0, ovr1_seen - o1);
    end
  endtask

  task automatic test_midword_reset();
    int v0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0, 1'b1);
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({d1_valid, d1_data, d0_valid, d0_data} !== 18'd0) begin
      failures++;
      $display("FAIL midreset_clear: got v=%b d=%h / v=%b d=%h required 0", d1_valid, d1_data, d0_valid, d0_data);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    v0 = vld1_seen;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ((vld1_seen - v0) !== 0 || d1_valid !== 1'b0 || d0_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_noword: got words=%0d v=%b/%b required 0", vld1_seen - v0, d1_valid, d0_valid);
    end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    for (int p = 1; p >= 0; p--) begin
      for (int i = 0; i < 8; i++) step(8'h07 >> (7 - i), 1'b1, i == 0, 1'b1);
      step(1'(p), 1'b1, 1'b0, 1'b1);
      checks++;
      if ({d1_valid, d1_data, d1_perr, d0_data, d0_perr} !== {1'b1, 8'h07, 1'(p == 0), rev8(8'h07), 1'(p == 0)}) begin
        failures++;
        $display("FAIL parity_p%0d: got v=%b d=%h perr=%b lsb=%h perr=%b required 1 07 %b %h",
                 p, d1_valid, d1_data, d1_perr, d0_data, d0_perr, p == 0, rev8(8'h07));
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (d1_perr !== 1'b0 || d0_perr !== 1'b0) begin
        failures++;
        $display("FAIL parity_pulse_end: got %b/%b required 0", d1_perr, d0_perr);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic s, v, y, r;
    int bad;
    reset_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 3000 && bad < 10; n++) begin
      s = 1'($urandom % 2);
      v = ($urandom % 4) != 0;
      y = v && (($urandom % 12) == 0);
      r = ($urandom % 3) != 0;
      step(s, v, y, r);
      checks++;
      if ({d1_valid, d1_data, d1_ovr, d1_perr} !== {m_full, m_data1, m_ovr, m_perr}) begin
        failures++; bad++;
        $display("FAIL rand_msb cyc=%0d: got v=%b d=%h o=%b p=%b required v=%b d=%h o=%b p=%b",
                 n, d1_valid, d1_data, d1_ovr, d1_perr, m_full, m_data1, m_ovr, m_perr);
      end
      checks++;
      if ({d0_valid, d0_data, d0_ovr, d0_perr} !== {m_full, m_data0, m_ovr, m_perr}) begin
        failures++; bad++;
        $display("FAIL rand_lsb cyc=%0d: got v=%b d=%h o=%b p=%b required v=%b d=%h o=%b p=%b",
                 n, d0_valid, d0_data, d0_ovr, d0_perr, m_full, m_data0, m_ovr, m_perr);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_word();
    test_backpressure();
    test_back_to_back();
    test_resync();
    test_midword_reset();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
